// File: rtl/maze_pkg.sv
// Shared definitions for the maze datapath: grid size, colour codes, renderer FSM
// states and the mapping between a map bit index and its on-screen cell.
package maze_pkg;

  localparam int GRID_DIM = 8;

  localparam logic [2:0] COL_FLOOR  = 3'b000;
  localparam logic [2:0] COL_WALL   = 3'b111;
  localparam logic [2:0] COL_START  = 3'b010;
  localparam logic [2:0] COL_FINISH = 3'b100;
  localparam logic [2:0] COL_PLAYER = 3'b001;
  localparam logic [2:0] COL_GRID   = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } cell_pos_t;

  // Bit 0 of a map is the top-right cell; columns run right-to-left within a row.
  function automatic cell_pos_t bit_to_cell(input logic [5:0] idx);
    cell_pos_t pos;
    pos.row = idx[5:3];
    pos.col = 3'd7 - idx[2:0];
    return pos;
  endfunction

  function automatic logic [5:0] cell_to_bit(input logic [2:0] row, input logic [2:0] col);
    return {row, 3'd7 - col};
  endfunction

  function automatic logic [2:0] cell_colour(input logic player, input logic finish,
                                             input logic start_cell, input logic wall);
    if (player)          return COL_PLAYER;
    else if (finish)     return COL_FINISH;
    else if (start_cell) return COL_START;
    else if (wall)       return COL_WALL;
    else                 return COL_FLOOR;
  endfunction

endpackage

// File: rtl/maze_frame_renderer_if.sv
// Bundle between the game controller / datapath (master) and the frame renderer (slave):
// request, the four 8x8 maps, status and the VGA plot outputs.
interface maze_frame_renderer_if;
  logic        start;
  logic [63:0] MMin;
  logic [63:0] FMin;
  logic [63:0] SMin;
  logic [63:0] PMin;
  logic        busy;
  logic        done;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  modport master (
    output start, MMin, FMin, SMin, PMin,
    input  busy, done, x, y, colour, plot
  );

  modport slave (
    input  start, MMin, FMin, SMin, PMin,
    output busy, done, x, y, colour, plot
  );
endinterface

// File: rtl/pixel_scan_counter.sv
// Raster counter over the grid's pixel area: px runs fastest, py steps when px wraps.
// last_o flags the final pixel of the frame.
module pixel_scan_counter #(
  parameter int CELL_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [CELL_LOG2+2:0] px_o,
  output logic [CELL_LOG2+2:0] py_o,
  output logic                 last_o
);
  localparam int PW = CELL_LOG2 + 3;

  logic [PW-1:0] px_q, px_d;
  logic [PW-1:0] py_q, py_d;

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (clr_i) begin
      px_d = '0;
      py_d = '0;
    end else if (en_i) begin
      px_d = px_q + 1'b1;
      if (&px_q) begin
        py_d = py_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  assign px_o   = px_q;
  assign py_o   = py_q;
  assign last_o = (&px_q) & (&py_q);
endmodule

// File: rtl/maze_frame_renderer.sv
// Snapshots the four maze maps on request and scans them out one pixel per cycle to the
// VGA plot interface. Build with GRID_LINES_EN defined to overlay cell grid lines.
module maze_frame_renderer
  import maze_pkg::*;
#(
  parameter int CELL_LOG2 = 3,
  parameter int X_ORIGIN  = 0,
  parameter int Y_ORIGIN  = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  maze_frame_renderer_if.slave  bus
);
  localparam int PW = CELL_LOG2 + 3;

  state_e state_q, state_d;

  logic [63:0] mm_q, mm_d;
  logic [63:0] fm_q, fm_d;
  logic [63:0] sm_q, sm_d;
  logic [63:0] pm_q, pm_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       plot_q, plot_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;

  logic [PW-1:0] px, py;
  logic          scan_last;
  logic          scan_clr, scan_en;

  pixel_scan_counter #(
    .CELL_LOG2 (CELL_LOG2)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clr_i  (scan_clr),
    .en_i   (scan_en),
    .px_o   (px),
    .py_o   (py),
    .last_o (scan_last)
  );

  // The top three bits of each offset are the cell column/row.
  logic [2:0] cell_row, cell_col;
  logic [5:0] cell_idx;
  logic [2:0] pix_colour;

  assign cell_col = px[PW-1 -: 3];
  assign cell_row = py[PW-1 -: 3];

`ifdef GRID_LINES_EN
  localparam logic [PW-1:0] OFF_MASK = PW'((1 << CELL_LOG2) - 1);
`endif

  always_comb begin
    cell_idx   = cell_to_bit(cell_row, cell_col);
    pix_colour = cell_colour(pm_q[cell_idx], fm_q[cell_idx], sm_q[cell_idx], mm_q[cell_idx]);
`ifdef GRID_LINES_EN
    if (((px & OFF_MASK) == '0) || ((py & OFF_MASK) == '0)) begin
      pix_colour = COL_GRID;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    mm_d     = mm_q;
    fm_d     = fm_q;
    sm_d     = sm_q;
    pm_d     = pm_q;
    busy_d   = busy_q;
    done_d   = done_q;
    plot_d   = plot_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    scan_clr = 1'b0;
    scan_en  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        plot_d = 1'b0;
        if (bus.start) begin
          mm_d     = bus.MMin;
          fm_d     = bus.FMin;
          sm_d     = bus.SMin;
          pm_d     = bus.PMin;
          scan_clr = 1'b1;
          busy_d   = 1'b1;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        plot_d   = 1'b1;
        x_d      = 8'(X_ORIGIN) + 8'(px);
        y_d      = 7'(Y_ORIGIN) + 7'(py);
        colour_d = pix_colour;
        scan_en  = 1'b1;
        if (scan_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        plot_d  = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mm_q     <= '0;
      fm_q     <= '0;
      sm_q     <= '0;
      pm_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      mm_q     <= mm_d;
      fm_q     <= fm_d;
      sm_q     <= sm_d;
      pm_q     <= pm_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.plot   = plot_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
endmodule

// File: tb/tb_maze_frame_renderer.sv
// Directed bench for maze_frame_renderer: expected pixels are queued per frame and
// popped by a monitor whenever plot is high; frame timing is checked per frame.
module tb_maze_frame_renderer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  maze_frame_renderer_if bus_if ();

  maze_frame_renderer #(
    .CELL_LOG2 (3),
    .X_ORIGIN  (0),
    .Y_ORIGIN  (0)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t sb[$];
  pix_t mon_exp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int plot_total = 0;
  int done_total = 0;
  int rise_cyc = -1;
  int last_plot_cyc = -1;
  int done_cyc = -1;
  logic prev_plot = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_colour(input logic [63:0] mm, input logic [63:0] fm,
                                            input logic [63:0] sm, input logic [63:0] pm,
                                            input int x, input int y);
    int i;
`ifdef GRID_LINES_EN
    if ((x % 8) == 0 || (y % 8) == 0) return 3'b011;
`endif
    i = (y / 8) * 8 + (7 - x / 8);
    if (pm[i])      return 3'b001;
    else if (fm[i]) return 3'b100;
    else if (sm[i]) return 3'b010;
    else if (mm[i]) return 3'b111;
    else            return 3'b000;
  endfunction

  // Monitor: every plotted pixel must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (bus_if.plot === 1'b1) begin
        plot_total++;
        if (!prev_plot) rise_cyc = cyc;
        last_plot_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_plot", 64'(bus_if.plot), 64'd0);
        end else begin
          mon_exp = sb.pop_front();
          check("pixel", 64'({bus_if.x, bus_if.y, bus_if.colour}), 64'(mon_exp));
        end
      end
      if (bus_if.done === 1'b1) begin
        done_total++;
        done_cyc = cyc;
      end
      prev_plot = (bus_if.plot === 1'b1);
    end else begin
      prev_plot = 1'b0;
    end
  end

  task automatic push_frame(input logic [63:0] mm, input logic [63:0] fm,
                            input logic [63:0] sm, input logic [63:0] pm);
    for (int py = 0; py < 64; py++) begin
      for (int px = 0; px < 64; px++) begin
        pix_t e;
        e.x = 8'(px);
        e.y = 7'(py);
        e.c = ref_colour(mm, fm, sm, pm, px, py);
        sb.push_back(e);
      end
    end
  endtask

  task automatic start_frame(input logic [63:0] mm, input logic [63:0] fm,
                             input logic [63:0] sm, input logic [63:0] pm,
                             output int start_cyc, output int base_plot, output int base_done);
    @(negedge clk);
    bus_if.MMin = mm;
    bus_if.FMin = fm;
    bus_if.SMin = sm;
    bus_if.PMin = pm;
    push_frame(mm, fm, sm, pm);
    base_plot = plot_total;
    base_done = done_total;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    check("busy_on_accept", 64'(bus_if.busy), 64'd1);
    check("no_plot_on_accept", 64'(bus_if.plot), 64'd0);
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int start_cyc, input int base_plot,
                              input int base_done, input bit expect_idle, input int remaining);
    int n = 0;
    while (done_total == base_done && n < 6000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, ":timeout"}, 64'(n < 6000), 64'd1);
    check({tag, ":plot_count"}, 64'(plot_total - base_plot), 64'd4096);
    check({tag, ":first_plot_cyc"}, 64'(rise_cyc), 64'(start_cyc + 1));
    check({tag, ":last_plot_cyc"}, 64'(last_plot_cyc), 64'(start_cyc + 4096));
    check({tag, ":done_cyc"}, 64'(done_cyc), 64'(last_plot_cyc + 1));
    check({tag, ":busy_in_done"}, 64'(bus_if.busy), 64'd1);
    check({tag, ":sb_left"}, 64'(sb.size()), 64'(remaining));
    @(negedge clk);
    #1;
    check({tag, ":done_single"}, 64'(done_total - base_done), 64'd1);
    check({tag, ":done_low_after"}, 64'(bus_if.done), 64'd0);
    if (expect_idle) check({tag, ":busy_low_after"}, 64'(bus_if.busy), 64'd0);
    $display("frame %s: %0d plots, done at cycle %0d", tag, plot_total - base_plot, done_cyc);
  endtask

  initial begin
    int s_cyc, b_plot, b_done, n, s2_cyc;
    logic [63:0] rmm, rfm, rsm, rpm;

    resetn = 1'b1;
    bus_if.start = 1'b0;
    bus_if.MMin = '0;
    bus_if.FMin = '0;
    bus_if.SMin = '0;
    bus_if.PMin = '0;

    // Reset mid-cycle: outputs must clear without a clock edge.
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_done", 64'(bus_if.done), 64'd0);
    check("rst_plot", 64'(bus_if.plot), 64'd0);
    check("rst_xyc", 64'({bus_if.x, bus_if.y, bus_if.colour}), 64'd0);
    $display("reset: busy=%0b done=%0b plot=%0b", bus_if.busy, bus_if.done, bus_if.plot);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    start_frame(64'h0, 64'h0, 64'h0, 64'h0, s_cyc, b_plot, b_done);
    finish_frame("all_zero", s_cyc, b_plot, b_done, 1'b1, 0);

    start_frame(64'h1, 64'h0, 64'h0, 64'h0, s_cyc, b_plot, b_done);
    finish_frame("wall_bit0", s_cyc, b_plot, b_done, 1'b1, 0);

    start_frame(64'h200, 64'h200, 64'h200, 64'h200, s_cyc, b_plot, b_done);
    finish_frame("player_prio", s_cyc, b_plot, b_done, 1'b1, 0);

    start_frame(64'h200, 64'h200, 64'h200, 64'h0, s_cyc, b_plot, b_done);
    finish_frame("finish_prio", s_cyc, b_plot, b_done, 1'b1, 0);

    rmm = {$urandom, $urandom};
    rfm = {$urandom, $urandom} & {$urandom, $urandom};
    rsm = {$urandom, $urandom} & {$urandom, $urandom};
    rpm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
    start_frame(rmm, rfm, rsm, rpm, s_cyc, b_plot, b_done);
    finish_frame("random_maps", s_cyc, b_plot, b_done, 1'b1, 0);

    // Start re-pulsed and walls changed mid-frame: neither may affect anything.
    start_frame(64'h0, 64'h0, 64'h0, 64'h0, s_cyc, b_plot, b_done);
    n = 0;
    while (plot_total - b_plot < 100 && n < 300) begin @(negedge clk); #1; n++; end
    check("reach_pixel100", 64'(plot_total - b_plot), 64'd100);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    n = 0;
    while (plot_total - b_plot < 200 && n < 300) begin @(negedge clk); #1; n++; end
    check("reach_pixel200", 64'(plot_total - b_plot), 64'd200);
    bus_if.MMin = '1;
    finish_frame("ignore_start", s_cyc, b_plot, b_done, 1'b1, 0);
    repeat (20) @(negedge clk);
    #1;
    check("ignore_start:no_second_frame", 64'(plot_total - b_plot), 64'd4096);
    check("ignore_start:no_second_done", 64'(done_total - b_done), 64'd1);
    bus_if.MMin = '0;

    // Abort mid-frame with reset.
    start_frame(64'hFFFF_0000_FFFF_0000, 64'h0, 64'h0, 64'h0, s_cyc, b_plot, b_done);
    n = 0;
    while (plot_total - b_plot < 1000 && n < 1200) begin @(negedge clk); #1; n++; end
    check("reach_pixel1000", 64'(plot_total - b_plot), 64'd1000);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("abort_plot", 64'(bus_if.plot), 64'd0);
    check("abort_busy", 64'(bus_if.busy), 64'd0);
    check("abort_xyc", 64'({bus_if.x, bus_if.y, bus_if.colour}), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_done", 64'(done_total - b_done), 64'd0);
    $display("abort: reset after %0d plots", plot_total - b_plot);

    start_frame(64'h8000_0000_0000_0001, 64'h0, 64'h0, 64'h0, s_cyc, b_plot, b_done);
    finish_frame("after_abort", s_cyc, b_plot, b_done, 1'b1, 0);

    // Start held high: two frames with one IDLE cycle between them.
    @(negedge clk);
    bus_if.MMin = 64'h0123_4567_89AB_CDEF;
    bus_if.PMin = 64'h0000_0010_0000_0000;
    push_frame(bus_if.MMin, 64'h0, 64'h0, bus_if.PMin);
    push_frame(bus_if.MMin, 64'h0, 64'h0, bus_if.PMin);
    b_plot = plot_total;
    b_done = done_total;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    s_cyc = cyc;
    finish_frame("b2b_first", s_cyc, b_plot, b_done, 1'b0, 4096);
    s2_cyc = done_cyc + 1;
    bus_if.start = 1'b0;
    finish_frame("b2b_second", s2_cyc, b_plot + 4096, b_done + 1, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
